// File: rtl/nzcv_flag_pkg.sv
// Shared definitions for the NZCV flag unit.
// Contents: flag bit indices, 4-bit condition codes EQ..AL, the default
// reset flag value, the nzcv_t flag type, and the logical-op merge helper.
package nzcv_flag_pkg;

  typedef logic [3:0] nzcv_t;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  localparam nzcv_t RESET_NZCV_DEF = 4'b0000;

  typedef enum logic [3:0] {
    COND_EQ = 4'd0,  COND_NE = 4'd1,  COND_CS = 4'd2,  COND_CC = 4'd3,
    COND_MI = 4'd4,  COND_PL = 4'd5,  COND_VS = 4'd6,  COND_VC = 4'd7,
    COND_HI = 4'd8,  COND_LS = 4'd9,  COND_GE = 4'd10, COND_LT = 4'd11,
    COND_GT = 4'd12, COND_LE = 4'd13, COND_AL = 4'd14
  } cond_e;

  // Logical/move ops produce N, Z and the shifter carry; V is kept.
  function automatic nzcv_t merge_logical(nzcv_t alu, nzcv_t cur);
    nzcv_t r;
    r         = alu;
    r[FLAG_V] = cur[FLAG_V];
    return r;
  endfunction

endpackage

// File: rtl/nzcv_flag_unit_stack.sv
// flag_save_stack: LIFO of DEPTH 4-bit flag entries for exception entry/return.
// Ports:
//   clk, rst          clock, async active-high reset (clears all entries)
//   push, pop, din    pop has priority; push ignored when full
//   top               entry[count-1], 0 when empty
//   count             occupied entries, saturates in 0..DEPTH
//   overflow          push (without pop) while full, combinational
//   underflow         pop while empty, combinational
module flag_save_stack
  import nzcv_flag_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       push,
  input  logic       pop,
  input  nzcv_t      din,
  output nzcv_t      top,
  output logic [2:0] count,
  output logic       overflow,
  output logic       underflow
);

  nzcv_t [DEPTH-1:0] mem;
  logic              full, empty;

  assign full      = (count == 3'(DEPTH));
  assign empty     = (count == 3'd0);
  assign underflow = pop & empty;
  assign overflow  = push & ~pop & full;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem   <= '0;
      count <= 3'd0;
    end else if (pop) begin
      if (!empty) count <= count - 3'd1;
    end else if (push && !full) begin
      for (int i = 0; i < DEPTH; i++)
        if (count == 3'(i)) mem[i] <= din;
      count <= count + 3'd1;
    end
  end

  always_comb begin
    top = '0;
    for (int i = 0; i < DEPTH; i++)
      if (count == 3'(i + 1)) top = mem[i];
  end

endmodule

// File: rtl/nzcv_flag_unit.sv
// nzcv_flag_unit: owns the architectural NZCV flags.
// Priority per cycle: exc_return > exc_entry > msr_we > ALU commit.
// Ports:
//   clk, rst                         clock, async active-high reset
//   alu_valid, alu_nzcv, s_bit,
//   logical_op, cond_pass            ALU flag result and commit qualifiers
//   msr_we, msr_nzcv                 MSR flag write
//   exc_entry, exc_return            push / pop of the save stack
//   nzcv                             registered flags
//   nzcv_fwd                         next-edge flags when NZCV_FLAG_BYPASS_EN
//                                    is defined, otherwise equal to nzcv
//   spsr_nzcv, save_count            top of save stack, occupancy
//   flags_updated                    pulse the cycle after an accepted update
//   save_err                         sticky overflow/underflow
// Optional macro: NZCV_FLAG_BYPASS_EN.
module nzcv_flag_unit
  import nzcv_flag_pkg::*;
#(
  parameter nzcv_t RESET_NZCV = RESET_NZCV_DEF,
  parameter int    SAVE_DEPTH = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       alu_valid,
  input  logic [3:0] alu_nzcv,
  input  logic       s_bit,
  input  logic       logical_op,
  input  logic       cond_pass,
  input  logic       msr_we,
  input  logic [3:0] msr_nzcv,
  input  logic       exc_entry,
  input  logic       exc_return,
  output logic [3:0] nzcv,
  output logic [3:0] nzcv_fwd,
  output logic [3:0] spsr_nzcv,
  output logic [2:0] save_count,
  output logic       flags_updated,
  output logic       save_err
);

  nzcv_t nzcv_nxt;
  logic  upd_nxt;
  logic  push, overflow, underflow;

  // Return wins over entry: a simultaneous entry neither pushes nor errors.
  assign push = exc_entry & ~exc_return;

  flag_save_stack #(.DEPTH(SAVE_DEPTH)) u_stack (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .pop       (exc_return),
    .din       (nzcv),
    .top       (spsr_nzcv),
    .count     (save_count),
    .overflow  (overflow),
    .underflow (underflow)
  );

  always_comb begin
    nzcv_nxt = nzcv;
    upd_nxt  = 1'b0;
    if (exc_return) begin
      if (save_count != 3'd0) begin
        nzcv_nxt = spsr_nzcv;
        upd_nxt  = 1'b1;
      end
    end else if (exc_entry) begin
      // Instruction is flushed: same-cycle ALU/MSR updates are discarded.
    end else if (msr_we) begin
      nzcv_nxt = msr_nzcv;
      upd_nxt  = 1'b1;
    end else if (alu_valid && s_bit && cond_pass) begin
      nzcv_nxt = logical_op ? merge_logical(alu_nzcv, nzcv) : alu_nzcv;
      upd_nxt  = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      nzcv          <= RESET_NZCV;
      flags_updated <= 1'b0;
      save_err      <= 1'b0;
    end else begin
      nzcv          <= nzcv_nxt;
      flags_updated <= upd_nxt;
      save_err      <= save_err | overflow | underflow;
    end
  end

`ifdef NZCV_FLAG_BYPASS_EN
  assign nzcv_fwd = nzcv_nxt;
`else
  assign nzcv_fwd = nzcv;
`endif

endmodule
